// File: rtl/aes_add_round_key_if.sv
// Handshake and data bundle between the MixColumns stage, the AddRoundKey
// stage and its downstream consumer.
interface aes_add_round_key_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         key_ready;

    modport master (
        output key_load, key_in, in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, out_round, key_ready
    );

    modport slave (
        input  key_load, key_in, in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, out_round, key_ready
    );
endinterface

// File: rtl/aes_add_round_key.sv
// AES-128 AddRoundKey stage with an on-the-fly iterative key expander.
// Each accepted state is XORed with the current round key; the schedule wraps after round NR.
module aes_add_round_key #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_add_round_key_if.slave    bus
);

    localparam logic [3:0] NR_L = 4'(NR);

    // Byte 0 of the table sits in the top eight bits.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        S_NOKEY = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] msb;
        msb  = 11'd2047 - {x, 3'b000};
        sbox = SBOX_TABLE[msb -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        // SubWord(RotWord(w3)): rotate left by one byte, then substitute.
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    endfunction

    state_t         state_r;
    logic [127:0]   cipher_key_r;
    logic [127:0]   round_key_r;
    logic [7:0]     rcon_r;
    logic [3:0]     round_cnt_r;
    logic           out_valid_r;
    logic [127:0]   out_state_r;
    logic [3:0]     out_round_r;
    logic           key_ready_r;

    logic           in_ready_s;
    logic           accept_s;
    logic [127:0]   next_key_s;

    assign in_ready_s = (state_r == S_RUN) && !bus.key_load && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign next_key_s = next_key(round_key_r, rcon_r);

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_state = out_state_r;
    assign bus.out_round = out_round_r;
    assign bus.key_ready = key_ready_r;

    // Control FSM, key schedule and one-deep output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_NOKEY;
            cipher_key_r <= 128'h0;
            round_key_r  <= 128'h0;
            rcon_r       <= 8'h01;
            round_cnt_r  <= 4'd0;
            out_valid_r  <= 1'b0;
            out_state_r  <= 128'h0;
            out_round_r  <= 4'd0;
            key_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                S_NOKEY: begin
                    if (bus.key_load) begin
                        cipher_key_r <= bus.key_in;
                        round_key_r  <= bus.key_in;
                        rcon_r       <= 8'h01;
                        round_cnt_r  <= 4'd0;
                        key_ready_r  <= 1'b1;
                        state_r      <= S_RUN;
                    end else begin
                        key_ready_r  <= 1'b0;
                    end
                    out_valid_r <= 1'b0;
                end
                S_RUN: begin
                    key_ready_r <= 1'b1;
                    if (bus.key_load) begin
                        // A new key abandons whatever block was in flight.
                        cipher_key_r <= bus.key_in;
                        round_key_r  <= bus.key_in;
                        rcon_r       <= 8'h01;
                        round_cnt_r  <= 4'd0;
                        out_valid_r  <= 1'b0;
                    end else if (accept_s) begin
                        out_state_r <= bus.in_state ^ round_key_r;
                        out_round_r <= round_cnt_r;
                        out_valid_r <= 1'b1;
                        if (round_cnt_r == NR_L) begin
                            round_key_r <= cipher_key_r;
                            rcon_r      <= 8'h01;
                            round_cnt_r <= 4'd0;
                        end else begin
                            round_key_r <= next_key_s;
                            rcon_r      <= xtime(rcon_r);
                            round_cnt_r <= round_cnt_r + 4'd1;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
                default: begin
                    state_r     <= S_NOKEY;
                    out_valid_r <= 1'b0;
                    key_ready_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_add_round_key.md
Name: aes_add_round_key

Overview:
- Registered AddRoundKey stage for the AES-128 datapath. Sits directly downstream of MixColumns and consumes its 128-bit state output.
- XORs each incoming state with the current round key. An internal iterative key expander produces that key.
- The expander advances one round key per accepted transaction, so no key storage outside the block is needed.
- Valid/ready handshake on both sides; one-deep output register.

Parameters:
NR, 10, number of rounds (AES-128 only; other values unsupported)

Ports:
clk        input   1    clock; all state updates on rising edge
rst_n      input   1    asynchronous active-low reset
key_load   input   1    one-cycle pulse: capture key_in as the cipher key
key_in     input   128  cipher key; bits [127:120] = byte 0
in_valid   input   1    in_state valid (from MixColumns, or from ShiftRows in the final round)
in_ready   output  1    stage can accept in_state this cycle
in_state   input   128  state; [127:96] = column 0, [127:120] = s[0][0] (same packing as MixColumns)
out_valid  output  1    out_state valid
out_ready  input   1    downstream accepts out_state
out_state  output  128  in_state XOR round key
out_round  output  4    round index 0..NR of the key applied to out_state
key_ready  output  1    a cipher key is loaded

Behaviour:
- Reset (async, rst_n=0): FSM=S_NOKEY; out_valid=0, out_state=0, out_round=0, key_ready=0, round_cnt=0, rcon=8'h01, key registers=0.
- FSM S_NOKEY: in_ready=0. key_load -> capture key_in into both cipher_key and round_key; round_cnt=0; rcon=01; go to S_RUN.
- FSM S_RUN: key_ready=1.
  - in_ready = !key_load && (!out_valid || out_ready).
  - key_load in S_RUN aborts the block in progress: reload cipher_key/round_key from key_in, round_cnt=0, rcon=01, out_valid cleared next cycle, nothing accepted that cycle.
- Accept (in_valid && in_ready), effective next edge:
  - out_state <= in_state ^ round_key; out_round <= round_cnt; out_valid <= 1.
  - round_key <= next_key(round_key, rcon); rcon <= xtime(rcon) (01,02,04,08,10,20,40,80,1b,36); round_cnt++.
  - When round_cnt==NR: instead round_key <= cipher_key, rcon <= 01, round_cnt <= 0. The next block starts with no key_load.
- next_key: words w0..w3 = [127:96]..[31:0].
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord maps bytes [a0 a1 a2 a3] -> [a1 a2 a3 a0].
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - SubWord uses 4 instances of the team's SubBytes S-box.
- Output handshake:
  - out_valid drops when out_ready=1 and there is no new accept.
  - out_state and out_round hold stable while out_valid && !out_ready.
  - Simultaneous drain and accept gives back-to-back throughput of 1 state/cycle.
- Latency: 1 cycle from accept to out_valid.
- out_round is the source of truth for the round controller. After out_round==NR, the next output carries round 0.
- Key expansion is combinational from registered round_key; no extra pipeline stage.

Test Plan:
- Reset/load: rst_n low mid-transfer -> out_valid=0, in_ready=0, key_ready=0 immediately. key_load with key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready=1 next cycle.
- Round 0: after the load above, in_state 3243f6a8885a308d313198a2e0370734 -> out_state 193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, one cycle later.
- Key sequence: feed 11 zero states back-to-back with out_ready=1.
  - out_state round 1 = a0fafe1788542cb123a339392a6c7605.
  - out_state round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - out_round 0..10, no bubbles.
- Wrap: a 12th zero state -> out_state 2b7e151628aed2a6abf7158809cf4f3c, out_round=0.
- Backpressure: out_ready=0 for 5 cycles with a valid output -> in_ready=0, out_state/out_round stable. Release -> the next state is accepted the same cycle and the key schedule advances exactly once.
- Abort: key_load with in_valid=1 at round 4 -> input not accepted, out_valid=0 next cycle. Next accepted input uses the new key with out_round=0.
